// File: rtl/phase_gen_if.sv
// rtl/phase_gen_if.sv - control/status bundle between the phase sequencer and its user
interface phase_gen_if;
    logic        run;
    logic [5:0]  op;
    logic [5:0]  irfunc;
    logic [4:0]  regimm;
    logic        md_done;
    logic [4:0]  p;
    logic        md_start;
    logic        instr_done;
    logic [31:0] retired;
    logic        illegal;
    logic        md_timeout;

    modport master (
        output run, op, irfunc, regimm, md_done,
        input  p, md_start, instr_done, retired, illegal, md_timeout
    );

    modport slave (
        input  run, op, irfunc, regimm, md_done,
        output p, md_start, instr_done, retired, illegal, md_timeout
    );
endinterface

// File: rtl/phase_gen.sv
// rtl/phase_gen.sv - multi-cycle one-hot phase sequencer with class-based phase skipping
module phase_gen #(
    parameter int IMEM_WAIT  = 0,
    parameter int MD_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       reset,
    phase_gen_if.slave bus
);
    localparam int IW = (IMEM_WAIT > 0) ? $clog2(IMEM_WAIT + 1) : 1;
    localparam int MW = $clog2(MD_TIMEOUT + 1);

    typedef enum logic [2:0] {S_P0, S_P1, S_P2, S_P3, S_P4, S_HALT} state_t;
    typedef enum logic [2:0] {C_ALU, C_JMP, C_MD, C_BR, C_LD, C_ST, C_ILL} cls_t;

    state_t        state, state_nx;
    cls_t          cls, cls_nx, cls_dec;
    logic [IW-1:0] imem_cnt, imem_cnt_nx;
    logic [MW-1:0] md_cnt, md_cnt_nx;
    logic          cap, cap_nx;
    logic          first, first_nx;
    logic [31:0]   retired, retired_nx;
    logic          illegal, illegal_nx;
    logic          timeout, timeout_nx;
    logic          md_start, instr_done;
    logic [4:0]    p_oh;
    logic          md_wait, done_seen, last;

    // The class is only consumed at the end of P1, so decode straight from the live IR fields
    always_comb begin
        cls_dec = C_ILL;
        case (bus.op)
            6'b000000: begin
                case (bus.irfunc)
                    6'b000000, 6'b000010, 6'b000011, 6'b000100, 6'b000110, 6'b000111,
                    6'b010000, 6'b010001, 6'b010010, 6'b010011,
                    6'b100000, 6'b100010, 6'b100011,
                    6'b100100, 6'b100101, 6'b100110, 6'b100111,
                    6'b101010, 6'b101011:                         cls_dec = C_ALU;
                    6'b001000, 6'b001001:                         cls_dec = C_JMP;
                    6'b011000, 6'b011001, 6'b011010, 6'b011011:   cls_dec = C_MD;
                    default:                                      cls_dec = C_ILL;
                endcase
            end
            6'b000001: if (bus.regimm == 5'b00000 || bus.regimm == 5'b00001) cls_dec = C_BR;
            6'b000010, 6'b000011:                                 cls_dec = C_JMP;
            6'b000100, 6'b000101, 6'b000110, 6'b000111:           cls_dec = C_BR;
            6'b001001, 6'b001010, 6'b001011, 6'b001100,
            6'b001101, 6'b001110, 6'b001111:                      cls_dec = C_ALU;
            6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101: cls_dec = C_LD;
            6'b101000, 6'b101001, 6'b101011:                      cls_dec = C_ST;
            default:                                              cls_dec = C_ILL;
        endcase
    end

    assign md_wait   = (state == S_P2) && (cls == C_MD);
    assign done_seen = (bus.md_done && bus.run) || cap;
    assign last      = ((state == S_P2) && (cls == C_BR)) ||
                       ((state == S_P3) && (cls == C_ST)) ||
                       (state == S_P4);

    // Next-state and pulse outputs; run=0 freezes everything except the md_done capture flag
    always_comb begin
        state_nx    = state;
        cls_nx      = cls;
        imem_cnt_nx = imem_cnt;
        md_cnt_nx   = md_cnt;
        cap_nx      = cap;
        first_nx    = first;
        retired_nx  = retired;
        illegal_nx  = illegal;
        timeout_nx  = timeout;
        md_start    = 1'b0;
        instr_done  = 1'b0;
        if (state == S_HALT) begin
            state_nx = S_HALT;
        end else if (!bus.run) begin
            if (md_wait && bus.md_done) cap_nx = 1'b1;
        end else begin
            md_start   = md_wait && first;
            instr_done = last;
            case (state)
                S_P0: begin
                    if (imem_cnt == IW'(IMEM_WAIT)) begin
                        state_nx    = S_P1;
                        imem_cnt_nx = '0;
                    end else begin
                        imem_cnt_nx = imem_cnt + 1'b1;
                    end
                end
                S_P1: begin
                    cls_nx = cls_dec;
                    if (cls_dec == C_ILL) begin
                        state_nx   = S_HALT;
                        illegal_nx = 1'b1;
                    end else begin
                        state_nx  = S_P2;
                        md_cnt_nx = '0;
                        cap_nx    = 1'b0;
                        first_nx  = 1'b1;
                    end
                end
                S_P2: begin
                    if (cls == C_MD) begin
                        first_nx = 1'b0;
                        if (done_seen) begin
                            state_nx = S_P4;
                            cap_nx   = 1'b0;
                        end else if (md_cnt == MW'(MD_TIMEOUT)) begin
                            state_nx   = S_HALT;
                            timeout_nx = 1'b1;
                            cap_nx     = 1'b0;
                        end else begin
                            md_cnt_nx = md_cnt + 1'b1;
                        end
                    end else begin
                        state_nx = (cls == C_LD || cls == C_ST) ? S_P3 : S_P4;
                    end
                end
                S_P3:    state_nx = S_P4;
                default: state_nx = state;
            endcase
            // The final phase of every class retires the instruction and refetches
            if (last) begin
                state_nx    = S_P0;
                imem_cnt_nx = '0;
                retired_nx  = retired + 32'd1;
            end
        end
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_P0;
            cls      <= C_ALU;
            imem_cnt <= '0;
            md_cnt   <= '0;
            cap      <= 1'b0;
            first    <= 1'b0;
            retired  <= 32'd0;
            illegal  <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_nx;
            cls      <= cls_nx;
            imem_cnt <= imem_cnt_nx;
            md_cnt   <= md_cnt_nx;
            cap      <= cap_nx;
            first    <= first_nx;
            retired  <= retired_nx;
            illegal  <= illegal_nx;
            timeout  <= timeout_nx;
        end
    end

    // One-hot phase vector; HALT is the only state that drives all zeros
    always_comb begin
        case (state)
            S_P0:    p_oh = 5'b00001;
            S_P1:    p_oh = 5'b00010;
            S_P2:    p_oh = 5'b00100;
            S_P3:    p_oh = 5'b01000;
            S_P4:    p_oh = 5'b10000;
            default: p_oh = 5'b00000;
        endcase
    end

    assign bus.p          = p_oh;
    assign bus.md_start   = md_start;
    assign bus.instr_done = instr_done;
    assign bus.retired    = retired;
    assign bus.illegal    = illegal;
    assign bus.md_timeout = timeout;
endmodule
